// File: rtl/parity_sweep_ctrl.sv
// Parity-checker sweep sequencer: drives a latched word range into an hc280-style
// checker, samples pe/po per slot and tallies even/odd/error results.
// Optional first-error capture ports are enabled by defining PARITY_ERR_CAPTURE_EN.
module parity_sweep_ctrl #(
   parameter int unsigned WORD_W = 9,
   parameter int unsigned SETTLE = 1
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              start,
   input  logic              enable,
   input  logic [WORD_W-1:0] first_word,
   input  logic [WORD_W-1:0] last_word,
   input  logic              pe,
   input  logic              po,
   output logic [WORD_W-1:0] pc_word,
   output logic              busy,
   output logic              done,
   output logic [WORD_W:0]   even_count,
   output logic [WORD_W:0]   odd_count,
   output logic [WORD_W:0]   err_count,
   output logic              err
`ifdef PARITY_ERR_CAPTURE_EN
   ,
   output logic [WORD_W-1:0] first_err_word,
   output logic              first_err_valid
`endif
);

   localparam int unsigned CNT_W = WORD_W + 1;
   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   logic [SET_W-1:0]  r_settle;
   logic [WORD_W-1:0] r_last;
   logic [WORD_W-1:0] r_pc_word;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_even;
   logic [CNT_W-1:0]  r_odd;
   logic [CNT_W-1:0]  r_errc;
   logic              r_err;
`ifdef PARITY_ERR_CAPTURE_EN
   logic [WORD_W-1:0] r_fe_word;
   logic              r_fe_valid;
`endif

   logic w_exp_pe;
   logic w_sample_err;
   logic w_last;

   // Even number of ones must give pe=1; po must always be the complement of pe.
   assign w_exp_pe     = ~^r_pc_word;
   assign w_sample_err = (pe != w_exp_pe) || (po != ~pe);
   assign w_last       = (r_pc_word == r_last);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state    <= S_IDLE;
         r_settle   <= '0;
         r_last     <= '0;
         r_pc_word  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_even     <= '0;
         r_odd      <= '0;
         r_errc     <= '0;
         r_err      <= 1'b0;
`ifdef PARITY_ERR_CAPTURE_EN
         r_fe_word  <= '0;
         r_fe_valid <= 1'b0;
`endif
      end else if (enable) begin
         // enable low freezes everything, including a pending done
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_last     <= last_word;
                  r_pc_word  <= first_word;
                  r_even     <= '0;
                  r_odd      <= '0;
                  r_errc     <= '0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_settle   <= '0;
                  r_state    <= S_DRIVE;
`ifdef PARITY_ERR_CAPTURE_EN
                  r_fe_word  <= '0;
                  r_fe_valid <= 1'b0;
`endif
               end
            end
            S_DRIVE: begin
               if (r_settle == SETTLE_LAST) begin
                  r_settle <= '0;
                  r_state  <= S_SAMPLE;
               end else begin
                  r_settle <= r_settle + SET_W'(1);
               end
            end
            S_SAMPLE: begin
               if (pe) r_even <= r_even + CNT_W'(1);
               if (po) r_odd  <= r_odd + CNT_W'(1);
               if (w_sample_err) begin
                  r_errc <= r_errc + CNT_W'(1);
                  r_err  <= 1'b1;
`ifdef PARITY_ERR_CAPTURE_EN
                  if (!r_fe_valid) begin
                     r_fe_word  <= r_pc_word;
                     r_fe_valid <= 1'b1;
                  end
`endif
               end
               if (w_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_pc_word <= r_pc_word + WORD_W'(1);
                  r_state   <= S_DRIVE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pc_word    = r_pc_word;
   assign busy       = r_busy;
   assign done       = r_done;
   assign even_count = r_even;
   assign odd_count  = r_odd;
   assign err_count  = r_errc;
   assign err        = r_err;
`ifdef PARITY_ERR_CAPTURE_EN
   assign first_err_word  = r_fe_word;
   assign first_err_valid = r_fe_valid;
`endif

endmodule
